// File: rtl/bip_control.sv
// BIP control unit: PC, instruction fetch/IR latch, decode to accumulator selects and RAM strobes; 3 or 4 cycles per instruction, i_valid=0 freezes.
// Define BIP_CYCLE_COUNT_EN to add the o_cycle_count port (active, non-halted cycles).
module bip_control #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_SEL_A           = 2
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_DATA-1:0]            i_instruction,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_pc,
  output logic [NB_OPERAND-1:0]         o_operand,
  output logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr,
  output logic                          o_rd_ram,
  output logic                          o_wr_ram,
  output logic [NB_SEL_A-1:0]           o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_op_code,
  output logic                          o_wr_acc,
  output logic                          o_halt
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]                   o_cycle_count
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [NB_SEL_A-1:0] SEL_RAM = 2'b00;
  localparam logic [NB_SEL_A-1:0] SEL_IMM = 2'b01;
  localparam logic [NB_SEL_A-1:0] SEL_ALU = 2'b10;

  state_t                          state;
  state_t                          next_state;
  logic [LOG2_N_INSMEM_ADDR-1:0]   pc;
  logic [NB_DATA-1:0]              ir;
  logic [NB_OPCODE-1:0]            opcode;
  logic                            mem_op;
  logic                            rd_ram;
  logic                            wr_ram;
  logic                            wr_acc;

  assign opcode = ir[NB_DATA-1 -: NB_OPCODE];
  assign mem_op = (opcode == OP_LD) || (opcode == OP_ADD) || (opcode == OP_SUB);

  // state register plus the PC/IR it sequences
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else if (i_valid) begin
      state <= next_state;
      if (state == DECODE)
        ir <= i_instruction;
      if (state == EXEC && opcode != OP_HLT)
        pc <= pc + LOG2_N_INSMEM_ADDR'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE:  next_state = EXEC;
      EXEC: begin
        if (opcode == OP_HLT)
          next_state = HALT;
        else if (mem_op)
          next_state = MEM;
        else
          next_state = FETCH;
      end
      MEM:     next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    rd_ram    = 1'b0;
    wr_ram    = 1'b0;
    wr_acc    = 1'b0;
    o_sel_a   = SEL_RAM;
    o_sel_b   = 1'b0;
    o_op_code = 1'b0;
    o_halt    = 1'b0;
    case (state)
      EXEC: begin
        case (opcode)
          OP_STO: wr_ram = 1'b1;
          OP_LD, OP_ADD, OP_SUB: rd_ram = 1'b1;
          OP_LDI: begin
            o_sel_a = SEL_IMM;
            wr_acc  = 1'b1;
          end
          OP_ADDI: begin
            o_sel_a   = SEL_ALU;
            o_sel_b   = 1'b1;
            o_op_code = 1'b1;
            wr_acc    = 1'b1;
          end
          OP_SUBI: begin
            o_sel_a = SEL_ALU;
            o_sel_b = 1'b1;
            wr_acc  = 1'b1;
          end
          default: ;
        endcase
      end
      // RAM read data arrives this cycle; keep the read and address up
      MEM: begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        case (opcode)
          OP_ADD: begin
            o_sel_a   = SEL_ALU;
            o_op_code = 1'b1;
          end
          OP_SUB:  o_sel_a = SEL_ALU;
          default: o_sel_a = SEL_RAM;
        endcase
      end
      HALT:    o_halt = 1'b1;
      default: ;
    endcase
  end

  assign o_rd_ram    = rd_ram & i_valid;
  assign o_wr_ram    = wr_ram & i_valid;
  assign o_wr_acc    = wr_acc & i_valid;
  assign o_pc        = pc;
  assign o_operand   = ir[NB_OPERAND-1:0];
  assign o_data_addr = ir[LOG2_N_DATA_ADDR-1:0];

`ifdef BIP_CYCLE_COUNT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      o_cycle_count <= '0;
    else if (i_valid && state != HALT)
      o_cycle_count <= o_cycle_count + 32'd1;
  end
`endif

endmodule
